// File: rtl/issue_pair_stage.sv
// ID-stage issue selector: picks single, dual or no issue from the two queue head
// entries, returns the pop count combinationally and registers the issued pair.
module issue_pair_stage #(
  parameter int CKPT_W = 8,
  parameter int EXC_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SBA_flush_w_i,
  input  logic                  CP0_excOccur_w_i,
  input  logic [1:0]            IQ_supplyValid_i,
  input  logic [63:0]           IQ_inst_p_i,
  input  logic [63:0]           IQ_VAddr_p_i,
  input  logic [1:0]            IQ_hasException_p_i,
  input  logic [2*EXC_W-1:0]    IQ_ExcCode_p_i,
  input  logic [1:0]            IQ_isRefill_p_i,
  input  logic [63:0]           IQ_predDest_p_i,
  input  logic [1:0]            IQ_predTake_p_i,
  input  logic [2*CKPT_W-1:0]   IQ_checkPoint_p_i,
  output logic [1:0]            ID_upDateMode_o,
  input  logic                  EX_ready_i,
  output logic [1:0]            ID_valid_o,
  output logic [63:0]           ID_inst_p_o,
  output logic [63:0]           ID_VAddr_p_o,
  output logic [1:0]            ID_hasException_p_o,
  output logic [2*EXC_W-1:0]    ID_ExcCode_p_o,
  output logic [1:0]            ID_isRefill_p_o,
  output logic [63:0]           ID_predDest_p_o,
  output logic [1:0]            ID_predTake_p_o,
  output logic [2*CKPT_W-1:0]   ID_checkPoint_p_o
);

  function automatic logic [4:0] dec_dst(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [5:0] fn);
    logic [4:0] d;
    d = '0;
    if (op == 6'h00) begin
      if (!(fn inside {6'h08, 6'h0c, 6'h0d, 6'h11, 6'h13, [6'h18:6'h1b]})) d = rd;
    end else if (op == 6'h01) begin
      if (rt inside {5'h10, 5'h11}) d = 5'd31;
    end else if (op == 6'h03) begin
      d = 5'd31;
    end else if (op inside {[6'h08:6'h0f], [6'h20:6'h26]}) begin
      d = rt;
    end else if (op == 6'h10 && rs == 5'h00) begin
      d = rt;
    end
    return d;
  endfunction

  // A zero destination means "no destination", so it can never create a hazard.
  function automatic logic dec_raw(input logic [5:0] op, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [4:0] d0);
    logic use_rs;
    logic use_rt;
    use_rs = !(op inside {6'h02, 6'h03, 6'h10});
    use_rt = (op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e}) ||
             (op == 6'h10 && rs == 5'h04);
    return (d0 != 5'd0) && ((use_rs && rs == d0) || (use_rt && rt == d0));
  endfunction

  function automatic logic is_branch(input logic [5:0] op, input logic [5:0] fn);
    return (op inside {[6'h01:6'h07]}) || (op == 6'h00 && fn inside {6'h08, 6'h09});
  endfunction

  function automatic logic is_solo(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h10) || (op inside {[6'h20:6'h26], 6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e}) ||
           (op == 6'h00 && fn inside {6'h0c, 6'h0d, [6'h10:6'h13], [6'h18:6'h1b]});
  endfunction

  logic [31:0] inst0, inst1;
  logic [5:0]  op0, fn0, op1, fn1;
  logic [4:0]  rs0, rt0, rd0, rs1, rt1, rd1;
  logic [4:0]  dst0, dst1;
  logic        flush, can_load, dual_ok;
  logic [1:0]  mode;

  logic [1:0]            valid_p1;
  logic [63:0]           inst_p1, vaddr_p1, pred_dest_p1;
  logic [1:0]            has_exc_p1, is_refill_p1, pred_take_p1;
  logic [2*EXC_W-1:0]    exc_code_p1;
  logic [2*CKPT_W-1:0]   ckpt_p1;

  assign inst0 = IQ_inst_p_i[31:0];
  assign inst1 = IQ_inst_p_i[63:32];
  assign op0 = inst0[31:26];
  assign rs0 = inst0[25:21];
  assign rt0 = inst0[20:16];
  assign rd0 = inst0[15:11];
  assign fn0 = inst0[5:0];
  assign op1 = inst1[31:26];
  assign rs1 = inst1[25:21];
  assign rt1 = inst1[20:16];
  assign rd1 = inst1[15:11];
  assign fn1 = inst1[5:0];

  assign dst0 = dec_dst(op0, rs0, rt0, rd0, fn0);
  assign dst1 = dec_dst(op1, rs1, rt1, rd1, fn1);

  assign flush    = SBA_flush_w_i | CP0_excOccur_w_i;
  assign can_load = !flush && (valid_p1 == 2'b00 || EX_ready_i);

  assign dual_ok = (IQ_supplyValid_i == 2'b11) &&
                   !IQ_hasException_p_i[0] && !IQ_hasException_p_i[1] &&
                   !is_solo(op0, fn0) && !is_solo(op1, fn1) &&
                   !is_branch(op1, fn1) &&
                   !dec_raw(op1, rs1, rt1, dst0) &&
                   !(dst0 != 5'd0 && dst0 == dst1);

  // A slot0 branch that cannot pair goes alone; its delay slot becomes next cycle's head.
  always_comb begin
    mode = 2'b00;
    if (rst && can_load) begin
      if (dual_ok) mode = 2'b11;
      else if (IQ_supplyValid_i[0]) mode = 2'b01;
    end
  end

  assign ID_upDateMode_o = mode;

  // ID/EX register: the mode encoding doubles as the slot-valid pattern.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_p1     <= '0;
      inst_p1      <= '0;
      vaddr_p1     <= '0;
      has_exc_p1   <= '0;
      exc_code_p1  <= '0;
      is_refill_p1 <= '0;
      pred_dest_p1 <= '0;
      pred_take_p1 <= '0;
      ckpt_p1      <= '0;
    end else if (flush) begin
      valid_p1 <= 2'b00;
    end else if (can_load) begin
      valid_p1 <= mode;
      if (mode != 2'b00) begin
        inst_p1      <= IQ_inst_p_i;
        vaddr_p1     <= IQ_VAddr_p_i;
        has_exc_p1   <= IQ_hasException_p_i;
        exc_code_p1  <= IQ_ExcCode_p_i;
        is_refill_p1 <= IQ_isRefill_p_i;
        pred_dest_p1 <= IQ_predDest_p_i;
        pred_take_p1 <= IQ_predTake_p_i;
        ckpt_p1      <= IQ_checkPoint_p_i;
      end
    end
  end

  assign ID_valid_o          = valid_p1;
  assign ID_inst_p_o         = inst_p1;
  assign ID_VAddr_p_o        = vaddr_p1;
  assign ID_hasException_p_o = has_exc_p1;
  assign ID_ExcCode_p_o      = exc_code_p1;
  assign ID_isRefill_p_o     = is_refill_p1;
  assign ID_predDest_p_o     = pred_dest_p1;
  assign ID_predTake_p_o     = pred_take_p1;
  assign ID_checkPoint_p_o   = ckpt_p1;

endmodule

// File: tb/tb_issue_pair_stage.sv
// Self-checking bench for issue_pair_stage: directed scenarios plus a randomized
// instruction queue checked against a behavioural issue model.
module tb_issue_pair_stage;
  localparam int CKPT_W = 8;
  localparam int EXC_W  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, SBA_flush_w_i, CP0_excOccur_w_i, EX_ready_i;
  logic [1:0] IQ_supplyValid_i, IQ_hasException_p_i, IQ_isRefill_p_i, IQ_predTake_p_i;
  logic [63:0] IQ_inst_p_i, IQ_VAddr_p_i, IQ_predDest_p_i;
  logic [2*EXC_W-1:0] IQ_ExcCode_p_i;
  logic [2*CKPT_W-1:0] IQ_checkPoint_p_i;
  logic [1:0] ID_upDateMode_o, ID_valid_o, ID_hasException_p_o, ID_isRefill_p_o, ID_predTake_p_o;
  logic [63:0] ID_inst_p_o, ID_VAddr_p_o, ID_predDest_p_o;
  logic [2*EXC_W-1:0] ID_ExcCode_p_o;
  logic [2*CKPT_W-1:0] ID_checkPoint_p_o;

  issue_pair_stage #(.CKPT_W(CKPT_W), .EXC_W(EXC_W)) dut (
    .clk(clk), .rst(rst), .SBA_flush_w_i(SBA_flush_w_i), .CP0_excOccur_w_i(CP0_excOccur_w_i),
    .IQ_supplyValid_i(IQ_supplyValid_i), .IQ_inst_p_i(IQ_inst_p_i), .IQ_VAddr_p_i(IQ_VAddr_p_i),
    .IQ_hasException_p_i(IQ_hasException_p_i), .IQ_ExcCode_p_i(IQ_ExcCode_p_i),
    .IQ_isRefill_p_i(IQ_isRefill_p_i), .IQ_predDest_p_i(IQ_predDest_p_i),
    .IQ_predTake_p_i(IQ_predTake_p_i), .IQ_checkPoint_p_i(IQ_checkPoint_p_i),
    .ID_upDateMode_o(ID_upDateMode_o), .EX_ready_i(EX_ready_i), .ID_valid_o(ID_valid_o),
    .ID_inst_p_o(ID_inst_p_o), .ID_VAddr_p_o(ID_VAddr_p_o),
    .ID_hasException_p_o(ID_hasException_p_o), .ID_ExcCode_p_o(ID_ExcCode_p_o),
    .ID_isRefill_p_o(ID_isRefill_p_o), .ID_predDest_p_o(ID_predDest_p_o),
    .ID_predTake_p_o(ID_predTake_p_o), .ID_checkPoint_p_o(ID_checkPoint_p_o)
  );

  // An instruction together with the properties its generator knows it has.
  typedef struct {
    logic [31:0] inst, va, pd;
    logic        exc, refill, take;
    logic [4:0]  code;
    logic [7:0]  ckpt;
    logic [4:0]  dst, s0, s1;
    logic        br, solo;
  } ent_t;

  ent_t e0, e1, m_s0, m_s1, zero_e;
  ent_t q[$];
  logic [1:0] sv, m_valid, em;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic ent_t mk(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [31:0] va);
    ent_t e;
    e.va = va; e.pd = va + 32'd8; e.exc = 1'b0; e.refill = 1'b0; e.take = 1'b0;
    e.code = 5'd0; e.ckpt = 8'd0; e.dst = 5'd0; e.s0 = 5'd0; e.s1 = 5'd0;
    e.br = 1'b0; e.solo = 1'b0; e.inst = 32'd0;
    case (kind)
      0:  begin e.inst = {6'h00, rs, rt, rd, 5'h0, 6'h21}; e.dst = rd; e.s0 = rs; e.s1 = rt; end
      1:  begin e.inst = {6'h0d, rs, rt, 16'h0001}; e.dst = rt; e.s0 = rs; end
      2:  begin e.inst = {6'h23, rs, rt, 16'h0010}; e.dst = rt; e.s0 = rs; e.solo = 1'b1; end
      3:  begin e.inst = {6'h2b, rs, rt, 16'h0010}; e.s0 = rs; e.s1 = rt; e.solo = 1'b1; end
      4:  begin e.inst = {6'h04, rs, rt, 16'h0004}; e.s0 = rs; e.s1 = rt; e.br = 1'b1; end
      5:  begin e.inst = {6'h02, 26'h10}; e.br = 1'b1; end
      6:  begin e.inst = {6'h03, 26'h10}; e.dst = 5'd31; e.br = 1'b1; end
      7:  begin e.inst = {6'h00, rs, 15'h0, 6'h08}; e.s0 = rs; e.br = 1'b1; end
      8:  begin e.inst = {6'h00, rs, rt, 10'h0, 6'h18}; e.s0 = rs; e.s1 = rt; e.solo = 1'b1; end
      9:  begin e.inst = {6'h10, 5'h00, rt, rd, 11'h0}; e.dst = rt; e.solo = 1'b1; end
      10: begin e.inst = {6'h01, rs, 5'h11, 16'h0004}; e.dst = 5'd31; e.s0 = rs; e.br = 1'b1; end
      11: begin e.inst = {6'h00, 20'h0, 6'h0c}; e.solo = 1'b1; end
      12: begin e.inst = {6'h0f, 5'h00, rt, 16'h1234}; e.dst = rt; end
      default: begin e.inst = {6'h00, rs, 5'h0, rd, 5'h0, 6'h09}; e.dst = rd; e.s0 = rs; e.br = 1'b1; end
    endcase
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e = mk($urandom_range(0, 13), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), {$urandom} & 32'hffff_fffc);
    e.exc = ($urandom_range(0, 11) == 0);
    e.code = 5'($urandom);
    e.refill = 1'($urandom);
    e.take = 1'($urandom);
    e.pd = $urandom;
    e.ckpt = 8'($urandom);
    return e;
  endfunction

  function automatic logic [111:0] pack_ent(input ent_t e);
    return {e.inst, e.va, e.pd, e.exc, e.code, e.refill, e.take, e.ckpt};
  endfunction

  function automatic logic [111:0] out_slot(input int k);
    if (k == 0)
      return {ID_inst_p_o[31:0], ID_VAddr_p_o[31:0], ID_predDest_p_o[31:0], ID_hasException_p_o[0],
              ID_ExcCode_p_o[4:0], ID_isRefill_p_o[0], ID_predTake_p_o[0], ID_checkPoint_p_o[7:0]};
    return {ID_inst_p_o[63:32], ID_VAddr_p_o[63:32], ID_predDest_p_o[63:32], ID_hasException_p_o[1],
            ID_ExcCode_p_o[9:5], ID_isRefill_p_o[1], ID_predTake_p_o[1], ID_checkPoint_p_o[15:8]};
  endfunction

  function automatic logic pair_ok();
    logic raw, waw;
    raw = (e0.dst != 0) && (e1.s0 == e0.dst || e1.s1 == e0.dst);
    waw = (e0.dst != 0) && (e0.dst == e1.dst);
    return sv == 2'b11 && !e0.exc && !e1.exc && !e0.solo && !e1.solo && !e1.br && !raw && !waw;
  endfunction

  function automatic logic [1:0] exp_mode();
    if (!rst || SBA_flush_w_i || CP0_excOccur_w_i) return 2'b00;
    if (m_valid != 2'b00 && !EX_ready_i) return 2'b00;
    if (pair_ok()) return 2'b11;
    if (sv[0]) return 2'b01;
    return 2'b00;
  endfunction

  task automatic settle(output logic [1:0] m);
    IQ_inst_p_i = {e1.inst, e0.inst};
    IQ_VAddr_p_i = {e1.va, e0.va};
    IQ_hasException_p_i = {e1.exc, e0.exc};
    IQ_ExcCode_p_i = {e1.code, e0.code};
    IQ_isRefill_p_i = {e1.refill, e0.refill};
    IQ_predDest_p_i = {e1.pd, e0.pd};
    IQ_predTake_p_i = {e1.take, e0.take};
    IQ_checkPoint_p_i = {e1.ckpt, e0.ckpt};
    IQ_supplyValid_i = sv;
    #1;
    m = exp_mode();
    chk("mode", ID_upDateMode_o, m);
  endtask

  // The model captures what the issue rules say the register holds after this edge.
  task automatic tick(input logic [1:0] m);
    if (!rst) begin
      m_valid = 2'b00; m_s0 = zero_e; m_s1 = zero_e;
    end else if (SBA_flush_w_i || CP0_excOccur_w_i) begin
      m_valid = 2'b00;
    end else if (m_valid == 2'b00 || EX_ready_i) begin
      if (m != 2'b00) m_s0 = e0;
      if (m == 2'b11) m_s1 = e1;
      m_valid = m;
    end
    @(posedge clk);
    #1;
    chk("valid", ID_valid_o, m_valid);
    if (m_valid[0] || !rst) chk("slot0", out_slot(0), pack_ent(m_s0));
    if (m_valid[1] || !rst) chk("slot1", out_slot(1), pack_ent(m_s1));
    @(negedge clk);
  endtask

  initial begin
    zero_e = mk(0, 5'd0, 5'd0, 5'd0, 32'd0);
    zero_e.inst = 32'd0; zero_e.pd = 32'd0;
    e0 = zero_e; e1 = zero_e; sv = 2'b00; m_valid = 2'b00; m_s0 = zero_e; m_s1 = zero_e;
    rst = 1'b0; SBA_flush_w_i = 1'b0; CP0_excOccur_w_i = 1'b0; EX_ready_i = 1'b1;
    @(negedge clk);

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      settle(em); tick(em);
    end
    chk("rst_valid", ID_valid_o, 2'b00);
    chk("rst_inst", ID_inst_p_o, 64'd0);
    rst = 1'b1;
    sv = 2'b00;
    settle(em);
    chk("rst_mode", ID_upDateMode_o, 2'b00);
    tick(em);

    // Independent ALU pair dual-issues
    e0 = mk(0, 5'd1, 5'd2, 5'd3, 32'h1000);
    e1 = mk(1, 5'd4, 5'd5, 5'd0, 32'h1004);
    sv = 2'b11;
    settle(em); chk("dual_mode", ID_upDateMode_o, 2'b11); tick(em);
    chk("dual_valid", ID_valid_o, 2'b11);
    chk("dual_pcs", ID_VAddr_p_o, 64'h00001004_00001000);

    // RAW splits the pair
    e0 = mk(0, 5'd1, 5'd2, 5'd3, 32'h2000);
    e1 = mk(0, 5'd3, 5'd4, 5'd6, 32'h2004);
    settle(em); chk("raw_mode", ID_upDateMode_o, 2'b01); tick(em);
    e0 = e1; sv = 2'b01;
    settle(em); chk("raw_second_mode", ID_upDateMode_o, 2'b01); tick(em);
    chk("raw_second_inst", ID_inst_p_o[31:0], 32'h00643021);

    // Branch in slot1 waits; branch plus delay slot pairs
    e0 = mk(0, 5'd1, 5'd2, 5'd7, 32'h3000);
    e1 = mk(4, 5'd1, 5'd2, 5'd0, 32'h3004);
    sv = 2'b11;
    settle(em); chk("br_slot1_mode", ID_upDateMode_o, 2'b01); tick(em);
    e0 = e1;
    e1 = mk(0, 5'd1, 5'd2, 5'd8, 32'h3008);
    settle(em); chk("br_pair_mode", ID_upDateMode_o, 2'b11); tick(em);

    // Back-pressure holds everything
    EX_ready_i = 1'b0;
    e0 = mk(1, 5'd1, 5'd9, 5'd0, 32'h4000);
    e1 = mk(1, 5'd2, 5'd10, 5'd0, 32'h4004);
    for (int i = 0; i < 3; i++) begin
      settle(em); chk("stall_mode", ID_upDateMode_o, 2'b00); tick(em);
      chk("stall_pcs", ID_VAddr_p_o, 64'h00003008_00003004);
    end
    EX_ready_i = 1'b1;
    settle(em); chk("unstall_mode", ID_upDateMode_o, 2'b11); tick(em);

    // Flush wins over a loadable pair
    SBA_flush_w_i = 1'b1;
    e0 = mk(0, 5'd1, 5'd2, 5'd3, 32'h5000);
    settle(em); chk("flush_mode", ID_upDateMode_o, 2'b00); tick(em);
    chk("flush_valid", ID_valid_o, 2'b00);
    SBA_flush_w_i = 1'b0;

    // Fetch exception forces single issue
    e0.exc = 1'b1; e0.code = 5'h04;
    settle(em); chk("exc_mode", ID_upDateMode_o, 2'b01); tick(em);
    chk("exc_code", ID_ExcCode_p_o[4:0], 5'h04);
    chk("exc_valid", ID_valid_o, 2'b01);

    // Reset during a stall discards the held pair
    e0 = mk(0, 5'd1, 5'd2, 5'd3, 32'h6000);
    settle(em); tick(em);
    EX_ready_i = 1'b0; rst = 1'b0;
    settle(em); tick(em);
    chk("rst_stall_valid", ID_valid_o, 2'b00);
    rst = 1'b1; EX_ready_i = 1'b1;

    // Randomized queue traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      while (q.size() < 4) q.push_back(rnd_ent());
      r = $urandom_range(0, 9);
      sv = (r == 0) ? 2'b00 : (r < 3) ? 2'b01 : 2'b11;
      e0 = q[0]; e1 = q[1];
      EX_ready_i = ($urandom_range(0, 3) != 0);
      SBA_flush_w_i = ($urandom_range(0, 29) == 0);
      CP0_excOccur_w_i = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 99) != 0);
      settle(em);
      tick(em);
      if (em == 2'b11) begin
        void'(q.pop_front()); void'(q.pop_front());
      end else if (em == 2'b01) begin
        void'(q.pop_front());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
